// File: rtl/req_arbiter16.sv
// req_arbiter16: 16-way round-robin arbiter for a single shared resource.
// Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog that aborts via timeout_err.

module req_arbiter16 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        res_resp,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        res_valid,
    output logic [15:0] done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_gnt;
    logic [3:0]  r_sel;
    logic [3:0]  r_ptr;
    logic        r_valid;

    logic [31:0] w_dbl;
    logic [15:0] w_rot;
    logic [3:0]  w_off;
    logic [3:0]  w_idx;
    logic [15:0] w_onehot;
    logic        w_any;

    // Rotate requests so bit 0 is the requester whose turn comes first
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[r_ptr +: 16];

    // Lowest set bit of the rotated vector is the winner offset
    always_comb begin
        w_off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 4'(i);
            end
        end
    end

    assign w_idx    = r_ptr + w_off;
    assign w_onehot = 16'd1 << w_idx;
    assign w_any    = |req;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_terr;

    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

    // Control FSM with registered grant, select and command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 16'd0;
            r_sel   <= 4'd0;
            r_ptr   <= 4'd0;
            r_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= 8'd0;
            r_terr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    r_terr <= 1'b0;
`endif
                    if (w_any) begin
                        r_state <= S_BUSY;
                        r_gnt   <= w_onehot;
                        r_sel   <= w_idx;
                        r_valid <= 1'b1;
                        r_ptr   <= w_idx + 4'd1;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= 8'd0;
`endif
                    end
                end
                S_BUSY: begin
                    if (res_resp) begin
                        r_state <= S_REL;
                        r_gnt   <= 16'd0;
                        r_valid <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_state <= S_REL;
                        r_gnt   <= 16'd0;
                        r_valid <= 1'b0;
                        r_terr  <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
`endif
                end
                S_REL: begin
`ifdef ARB_TIMEOUT_EN
                    r_terr  <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 16'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign res_valid = r_valid;

    // Completion goes straight back to the granted requester
    assign done = (!rst && r_state == S_BUSY && res_resp)
                ? r_gnt : 16'd0;

endmodule

// File: tb/tb_req_arbiter16.sv
// tb_req_arbiter16: directed plus randomized checks of req_arbiter16
// against a transaction-level round-robin reference model.

module tb_req_arbiter16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        res_resp;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        res_valid;
    logic [15:0] done;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;
    int m_sel = 0;

    always #5 clk = ~clk;

    req_arbiter16 #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .res_resp    (res_resp),
        .gnt         (gnt),
        .sel         (sel),
        .res_valid   (res_valid),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int winner(logic [15:0] r, int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(string tag);
        chk({tag, "_gnt"}, gnt, 16'd0);
        chk({tag, "_valid"}, 16'(res_valid), 16'd0);
        chk({tag, "_sel"}, 16'(sel), 16'(m_sel));
        chk({tag, "_done"}, done, 16'd0);
        chk({tag, "_terr"}, 16'(timeout_err), 16'd0);
    endtask

    task automatic txn(input logic [15:0] r, input int lat,
                       input bit noise, input bit drop,
                       input bit rel_resp);
        int w;
        logic [15:0] oh;
        req = r;
        res_resp = 1'b0;
        w = winner(r, m_ptr);
        oh = 16'h0001 << w;
        tick();
        chk("grant_gnt", gnt, oh);
        chk("grant_sel", 16'(sel), 16'(w));
        chk("grant_valid", 16'(res_valid), 16'd1);
        chk("grant_done", done, 16'd0);
        m_ptr = (w + 1) % 16;
        m_sel = w;
        for (int k = 0; k < lat; k++) begin
            if (noise) req = 16'($urandom);
            if (drop) req = req & ~oh;
            tick();
            chk("busy_gnt", gnt, oh);
            chk("busy_sel", 16'(sel), 16'(w));
            chk("busy_valid", 16'(res_valid), 16'd1);
            chk("busy_done", done, 16'd0);
            chk("busy_terr", 16'(timeout_err), 16'd0);
        end
        res_resp = 1'b1;
        #1;
        chk("resp_done", done, oh);
        tick();
        res_resp = rel_resp;
        if (drop) req = req & ~oh;
        #1;
        chk("rel_gnt", gnt, 16'd0);
        chk("rel_valid", 16'(res_valid), 16'd0);
        chk("rel_sel", 16'(sel), 16'(w));
        chk("rel_done", done, 16'd0);
        chk("rel_terr", 16'(timeout_err), 16'd0);
        tick();
        res_resp = 1'b0;
        idle_chk("back_idle");
    endtask

    initial begin
        logic [15:0] r;
        int w;
        logic [15:0] oh;

        rst = 1'b1;
        req = 16'd0;
        res_resp = 1'b0;
        tick();
        tick();
        res_resp = 1'b1;
        #1;
        chk("rst_done", done, 16'd0);
        idle_chk("rst");
        rst = 1'b0;
        res_resp = 1'b0;

        // single requester, response two cycles after grant
        txn(16'h0001, 2, 1'b0, 1'b1, 1'b0);

        // all requesters held: 0..15 then wrap to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_sel = 0;
        idle_chk("rst2");
        for (int i = 0; i < 17; i++) begin
            txn(16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
            chk("rr_order", 16'(sel), 16'(i % 16));
        end

        // wrap past the pointer: 4 then 0, pointer lands on 1
        txn(16'h0010, 0, 1'b0, 1'b1, 1'b0);
        chk("grant4", 16'(sel), 16'd4);
        txn(16'h0011, 0, 1'b0, 1'b1, 1'b0);
        chk("wrap0", 16'(sel), 16'd0);
        txn(16'h0003, 0, 1'b0, 1'b1, 1'b0);
        chk("ptr_is_1", 16'(sel), 16'd1);

        // stray responses in IDLE and RELEASE
        req = 16'd0;
        res_resp = 1'b1;
        #1;
        chk("idle_resp_done", done, 16'd0);
        tick();
        res_resp = 1'b0;
        idle_chk("idle_resp");
        tick();
        idle_chk("idle_resp2");
        txn(16'h0040, 1, 1'b0, 1'b1, 1'b1);

        // reset in the middle of a transaction
        req = 16'h0100;
        tick();
        chk("pre_rst_gnt", gnt, 16'h0100);
        rst = 1'b1;
        res_resp = 1'b1;
        #1;
        chk("rst_busy_done", done, 16'd0);
        tick();
        rst = 1'b0;
        res_resp = 1'b0;
        m_ptr = 0;
        m_sel = 0;
        idle_chk("mid_rst");
        txn(16'h0100, 1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_sel", 16'(sel), 16'd8);

`ifdef ARB_TIMEOUT_EN
        // watchdog: four BUSY cycles without response
        req = 16'h0001;
        w = winner(req, m_ptr);
        oh = 16'h0001 << w;
        tick();
        chk("to_gnt", gnt, oh);
        m_ptr = (w + 1) % 16;
        m_sel = w;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("to_busy_gnt", gnt, oh);
            chk("to_busy_terr", 16'(timeout_err), 16'd0);
            chk("to_busy_done", done, 16'd0);
        end
        req = 16'd0;
        tick();
        chk("to_terr", 16'(timeout_err), 16'd1);
        chk("to_rel_gnt", gnt, 16'd0);
        chk("to_rel_valid", 16'(res_valid), 16'd0);
        chk("to_rel_done", done, 16'd0);
        tick();
        idle_chk("to_idle");
        // response in the last allowed cycle wins
        txn(16'h0002, 3, 1'b0, 1'b1, 1'b0);
`else
        // no watchdog: BUSY waits indefinitely
        req = 16'h0001;
        w = winner(req, m_ptr);
        oh = 16'h0001 << w;
        tick();
        m_ptr = (w + 1) % 16;
        m_sel = w;
        for (int c = 0; c < 300; c++) begin
            tick();
            chk("hold_gnt", gnt, oh);
            chk("hold_terr", 16'(timeout_err), 16'd0);
        end
        res_resp = 1'b1;
        #1;
        chk("hold_done", done, oh);
        tick();
        res_resp = 1'b0;
        req = 16'd0;
        tick();
        idle_chk("hold_idle");
`endif

        // randomized traffic with idle gaps and noise
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                req = 16'd0;
                tick();
                idle_chk("gap");
            end
            r = 16'($urandom) & 16'($urandom);
            if (r == 16'd0) r = 16'h8000;
            txn(r, $urandom_range(0, 2),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
